// File: rtl/led_disp_arbiter.sv
// led_disp_arbiter
// Shares the single 8-bit LED/segment bank between NUM_REQ pattern sources.
// Ownership rotates round-robin on a millisecond slice timer. Every hand-over
// passes through one blanked GAP cycle, so two grants are never high together.
//
// Parameters
//   CLK_IN_MHZ   input clock in MHz; one ms tick every CLK_IN_MHZ*1000 cycles
//   NUM_REQ      number of requesters (2..8)
//   SLICE_MS     ownership slice length in ms ticks (>= 1)
//   BLINK_MS     fault-code blink half-period in ms ticks (>= 1)
//   LED_POLARITY 1: active-high pins, 0: pins inverted
//
// Ports
//   clk_i          system clock
//   rstn_i         asynchronous active-low reset
//   req_i          per-requester level request, held while owning
//   data_i         pattern of requester i in bits [8i+7:8i], 1 = lit
//   fault_i        fault override request (level)
//   fault_code_i   pattern shown while in fault
//   gnt_o          registered one-hot grant
//   owner_o        registered index of current/last owner
//   led_display_o  registered pin drive, polarity applied
//
// Build option
//   LED_ARB_FAULT_EN  compile in the blinking fault-code override. Without
//                     it fault_i / fault_code_i are ignored.

module led_disp_arbiter #(
  parameter int unsigned CLK_IN_MHZ   = 100,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned SLICE_MS     = 500,
  parameter int unsigned BLINK_MS     = 250,
  parameter logic        LED_POLARITY = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*8-1:0]       data_i,
  input  logic                       fault_i,
  input  logic [7:0]                 fault_code_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] owner_o,
  output logic [7:0]                 led_display_o
);

  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned PRE_CNT = CLK_IN_MHZ * 1000;
  localparam int unsigned PRE_W   = $clog2(PRE_CNT);
  localparam int unsigned SL_W    = (SLICE_MS > 1) ? $clog2(SLICE_MS) : 1;

  // Pin value that shows a blank (logical 0x00) bank.
  localparam logic [7:0] PINS_BLANK = {8{~LED_POLARITY}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    GAP   = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [7:0]         disp_q, disp_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [SL_W-1:0]    slice_q, slice_d;
  logic               tick;

  // Round-robin search results, both starting at owner_q+1.
  // any_*: all NUM_REQ positions (the last one checked is the owner itself).
  // oth_*: only the NUM_REQ-1 positions other than the owner.
  logic               any_found, oth_found;
  logic [IDX_W-1:0]   any_idx, oth_idx, cand;
  logic [7:0]         own_pat, disp_log;

`ifdef LED_ARB_FAULT_EN
  localparam int unsigned BL_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  logic [BL_W-1:0]    blink_q, blink_d;
  logic               phase_q, phase_d;
`else
  // Ports kept for drop-in compatibility; feature not built.
  logic               unused_fault;
  assign unused_fault = fault_i ^ (^fault_code_i);
`endif

  // ------------------------------------------------------------------
  // Free-running millisecond prescaler
  // ------------------------------------------------------------------
  assign tick  = (pre_q == PRE_W'(PRE_CNT - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  // ------------------------------------------------------------------
  // Round-robin search
  // ------------------------------------------------------------------
  always_comb begin
    any_found = 1'b0;
    any_idx   = owner_q;
    oth_found = 1'b0;
    oth_idx   = owner_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((32'(owner_q) + k) % NUM_REQ);
      if (!any_found && req_i[cand]) begin
        any_found = 1'b1;
        any_idx   = cand;
      end
      if ((k < NUM_REQ) && !oth_found && req_i[cand]) begin
        oth_found = 1'b1;
        oth_idx   = cand;
      end
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    slice_d = slice_q;
`ifdef LED_ARB_FAULT_EN
    blink_d = blink_q;
    phase_d = phase_q;
`endif

    unique case (state_q)
      IDLE, GAP: begin
        if (any_found) begin
          state_d = OWN;
          owner_d = any_idx;
          slice_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      OWN: begin
        // A dropped request ends the slice at once and also wins over a
        // simultaneous slice expiry, so only one GAP ever results.
        if (!req_i[owner_q]) begin
          state_d = GAP;
        end else if (tick) begin
          if (slice_q == SL_W'(SLICE_MS - 1)) begin
            slice_d = '0;
            if (oth_found) begin
              state_d = GAP;
            end
          end else begin
            slice_d = slice_q + 1'b1;
          end
        end
      end

      FAULT: begin
`ifdef LED_ARB_FAULT_EN
        if (!fault_i) begin
          state_d = GAP;
          slice_d = '0;
        end else if (tick) begin
          if (blink_q == BL_W'(BLINK_MS - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
`else
        state_d = GAP;
`endif
      end

      default: state_d = IDLE;
    endcase

`ifdef LED_ARB_FAULT_EN
    // Fault override pre-empts every state; blink restarts lit.
    if (fault_i && (state_q != FAULT)) begin
      state_d = FAULT;
      blink_d = '0;
      phase_d = 1'b1;
    end
`endif
  end

  // Grant mirrors the next state so it is registered together with it.
  always_comb begin
    gnt_d = '0;
    if (state_d == OWN) begin
      gnt_d[owner_d] = 1'b1;
    end
  end

  // Display is computed from the current (registered) state, giving the
  // one-cycle lag behind both the grant and data_i.
  assign own_pat = data_i[{owner_q, 3'b000} +: 8];

  always_comb begin
    disp_log = '0;
    if (state_q == OWN) begin
      disp_log = own_pat;
    end
`ifdef LED_ARB_FAULT_EN
    else if ((state_q == FAULT) && phase_q) begin
      disp_log = fault_code_i;
    end
`endif
    disp_d = LED_POLARITY ? disp_log : ~disp_log;
  end

  // ------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      disp_q  <= PINS_BLANK;
      pre_q   <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      disp_q  <= disp_d;
      pre_q   <= pre_d;
      slice_q <= slice_d;
    end
  end

`ifdef LED_ARB_FAULT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_q <= '0;
      phase_q <= 1'b1;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign gnt_o         = gnt_q;
  assign owner_o       = owner_q;
  assign led_display_o = disp_q;

endmodule

// File: tb/tb_led_disp_arbiter.sv
// Testbench for led_disp_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the arbitration rules.

module tb_led_disp_arbiter;

  localparam int NUM   = 4;
  localparam int MHZ   = 1;
  localparam int SLICE = 2;
  localparam int BLINK = 1;
  localparam int PRE   = MHZ * 1000;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [31:0] data;
  logic        fault;
  logic [7:0]  fcode;
  logic [3:0]  gnt, gnt_n;
  logic [1:0]  own, own_n;
  logic [7:0]  pins, pins_n;

  always #5 clk = ~clk;

  led_disp_arbiter #(
    .CLK_IN_MHZ(MHZ), .NUM_REQ(NUM), .SLICE_MS(SLICE),
    .BLINK_MS(BLINK), .LED_POLARITY(1'b1)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .data_i(data),
    .fault_i(fault), .fault_code_i(fcode),
    .gnt_o(gnt), .owner_o(own), .led_display_o(pins)
  );

  led_disp_arbiter #(
    .CLK_IN_MHZ(MHZ), .NUM_REQ(NUM), .SLICE_MS(SLICE),
    .BLINK_MS(BLINK), .LED_POLARITY(1'b0)
  ) dut_n (
    .clk_i(clk), .rstn_i(rstn), .req_i(req), .data_i(data),
    .fault_i(fault), .fault_code_i(fcode),
    .gnt_o(gnt_n), .owner_o(own_n), .led_display_o(pins_n)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_OWN, M_GAP, M_FAULT} mmode_e;
  mmode_e     m_mode;
  int         m_n;      // clock edges since reset release
  int         m_owner;
  int         m_ms;     // ms ticks elapsed in the current slice
  int         m_blink;
  bit         m_lit;
  logic [7:0] m_disp;   // logical pattern on the bank

  function automatic int pick(input logic [3:0] r, input int last, input int span);
    for (int k = 1; k <= span; k++) begin
      int c;
      c = (last + k) % NUM;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_n     = 0;
    m_owner = NUM - 1;
    m_ms    = 0;
    m_blink = 0;
    m_lit   = 1'b1;
    m_disp  = 8'h00;
  endtask

  task automatic model_advance();
    bit tk;
    int nxt;
    bit took_fault;
    tk = ((m_n % PRE) == PRE - 1);
    if (m_mode == M_OWN) m_disp = data[m_owner*8 +: 8];
    else if (m_mode == M_FAULT && m_lit) m_disp = fcode;
    else m_disp = 8'h00;
    took_fault = 1'b0;
`ifdef LED_ARB_FAULT_EN
    if (fault && m_mode != M_FAULT) begin
      m_mode = M_FAULT; m_blink = 0; m_lit = 1'b1; took_fault = 1'b1;
    end
`endif
    if (!took_fault) begin
      case (m_mode)
        M_IDLE, M_GAP: begin
          nxt = pick(req, m_owner, NUM);
          if (nxt >= 0) begin
            m_mode = M_OWN; m_owner = nxt; m_ms = 0;
          end else begin
            m_mode = M_IDLE;
          end
        end
        M_OWN: begin
          if (!req[m_owner]) m_mode = M_GAP;
          else if (tk) begin
            m_ms++;
            if (m_ms == SLICE) begin
              m_ms = 0;
              if (pick(req, m_owner, NUM - 1) >= 0) m_mode = M_GAP;
            end
          end
        end
        M_FAULT: begin
          if (!fault) m_mode = M_GAP;
          else if (tk) begin
            m_blink++;
            if (m_blink == BLINK) begin m_blink = 0; m_lit = !m_lit; end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    m_n++;
  endtask

  task automatic check_all();
    logic [7:0] inv;
    logic [3:0] eg;
    inv = ~m_disp;
    eg  = (m_mode == M_OWN) ? 4'(1 << m_owner) : 4'b0000;
    chk("gnt", gnt, eg);
    chk("owner", own, m_owner);
    chk("pins", pins, m_disp);
    chk("pins_inv", pins_n, inv);
    chk("gnt_inv_inst", gnt_n, eg);
  endtask

  // One clock: model consumes the inputs now on the pins, DUT sees the edge,
  // then outputs are compared at the following falling edge.
  task automatic cyc();
    model_advance();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    req = '0; fault = 1'b0; rstn = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_all();
    end
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] qget(input logic [7:0] q[$], input int i);
    if (q.size() > i) return {24'h0, q[i]};
    return 32'hDEAD;
  endfunction

  initial begin
    int run1, stage, stuck, fleft;
    bit granted;
    logic [3:0] after1, after2;
    logic [7:0] dq[$];

    rstn = 1'b0; req = '0; data = '0; fault = 1'b0; fcode = '0;

    // ---- reset values, then two requesters sharing the bank ----
    do_reset();
    chk("rst_owner", own, 2'd3);
    chk("rst_pins_inv", pins_n, 8'hFF);
    data = {8'h00, 8'h22, 8'h00, 8'h11};
    req  = 4'b0101;
    run1 = 0; stage = 0; after1 = 4'hF; after2 = 4'hF;
    dq.push_back(pins);
    for (int i = 0; i < 5000; i++) begin
      cyc();
      if (dq[$] != pins) dq.push_back(pins);
      case (stage)
        0: if (gnt == 4'b0001) begin stage = 1; run1 = 1; end
        1: if (gnt == 4'b0001) run1++; else begin after1 = gnt; stage = 2; end
        2: begin after2 = gnt; stage = 3; end
        default: ;
      endcase
    end
    chk("slice_len_in_range", 32'(run1 >= 1000 && run1 <= 3000), 1);
    chk("handover_gap", after1, 4'b0000);
    chk("handover_next", after2, 4'b0100);
    chk("disp_seq0", qget(dq, 1), 32'h11);
    chk("disp_seq1", qget(dq, 2), 32'h00);
    chk("disp_seq2", qget(dq, 3), 32'h22);

    // ---- single requester keeps the bank across slice boundaries ----
    do_reset();
    req = 4'b1000; data = 32'h5A00_0000;
    stuck = 0; granted = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      cyc();
      if (gnt == 4'b1000) granted = 1'b1;
      else if (granted) stuck++;
    end
    chk("single_granted", 32'(granted), 1);
    chk("single_no_gap", stuck, 0);

    // ---- owner drops mid-slice while another is pending ----
    do_reset();
    req = 4'b0010;
    repeat (5) cyc();
    req = 4'b1010;
    repeat (400) cyc();
    chk("drop_pre", gnt, 4'b0010);
    req = 4'b1000;
    cyc();
    chk("drop_gap", gnt, 4'b0000);
    cyc();
    chk("drop_next", gnt, 4'b1000);
    chk("drop_owner", own, 2'd3);

`ifdef LED_ARB_FAULT_EN
    // ---- fault override ----
    req = 4'b0011; fcode = 8'hA5; fault = 1'b1;
    repeat (5000) cyc();
    chk("fault_gnt", gnt, 4'b0000);
    fault = 1'b0;
    cyc();
    chk("fault_exit_gap", gnt, 4'b0000);
    repeat (5) cyc();
`endif

    // ---- randomized traffic ----
    do_reset();
    fleft = 0;
    for (int i = 0; i < 30000; i++) begin
      data  = $urandom;
      fcode = 8'($urandom);
      if ($urandom_range(0, 1199) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2999) == 0) req[m_owner] = 1'b0;
`ifdef LED_ARB_FAULT_EN
      if (fleft == 0 && $urandom_range(0, 9999) == 0) fleft = $urandom_range(1500, 4000);
      fault = (fleft > 0);
      if (fleft > 0) fleft--;
`else
      fault = 1'($urandom);
`endif
      cyc();
    end
    fault = 1'b0;

    // ---- asynchronous reset in the middle of a slice ----
    req = 4'b1111;
    repeat (50) cyc();
    chk("pre_rst_own", 32'(gnt != 4'b0000), 1);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("async_gnt", gnt, 4'b0000);
    chk("async_pins", pins, 8'h00);
    chk("async_pins_inv", pins_n, 8'hFF);
    chk("async_owner", own, 2'd3);
    do_reset();
    req = 4'b0110;
    cyc();
    chk("post_rst_first", gnt, 4'b0010);
    repeat (20) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
